// File: rtl/i2s_tx_scheduler.sv
// I2S master transmitter: sck/ws generation, one-frame holding register, MSB-first serializer.
// Optional build macro I2S_TX_REPEAT_ON_UNDERRUN_EN resends the previous pair on underrun.
module i2s_tx_scheduler #(
    parameter int CYC_PER_HALF_SCK = 33,
    parameter int BITS             = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] sample_l,
    input  logic [BITS-1:0] sample_r,
    input  logic            sample_valid,
    output logic            sample_ready,
    output logic            i2so_sck,
    output logic            i2so_ws,
    output logic            i2so_sd,
    output logic            frame_start,
    output logic            underrun
);
    localparam int CW = $clog2(CYC_PER_HALF_SCK + 1);
    localparam int PW = $clog2(2 * BITS);
    localparam int BW = $clog2(BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYC_PER_HALF_SCK - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(2 * BITS - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            sck_q, sck_d;
    logic            ws_q, ws_d;
    logic            sd_q, sd_d;
    logic            fs_q, fs_d;
    logic            un_q, un_d;
    logic [BITS-1:0] sh_l_q, sh_l_d;
    logic [BITS-1:0] sh_r_q, sh_r_d;
    logic [BITS-1:0] hd_l_q, hd_l_d;
    logic [BITS-1:0] hd_r_q, hd_r_d;
    logic            full_q, full_d;
    logic            rdy_q, rdy_d;

    logic            tick;
    logic            fall;
    logic            wrap;
    logic            xfer;
    logic            bypass;
    logic            lr;
    logic [PW-1:0]   pos_nx;
    logic [PW-1:0]   rel;
    logic [BW-1:0]   bidx;
    logic [BITS-1:0] word;

    always_comb begin
        tick   = en && (cnt_q == CNT_LAST);
        fall   = tick && sck_q;
        wrap   = fall && (pos_q == POS_LAST);
        xfer   = sample_valid && rdy_q;
        bypass = wrap && !full_q && sample_valid;
        pos_nx = wrap ? '0 : pos_q + 1'b1;

        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        sck_d  = tick ? ~sck_q : sck_q;
        pos_d  = fall ? pos_nx : pos_q;
        ws_d   = ws_q;
        sd_d   = sd_q;
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;
        fs_d   = wrap;
        un_d   = wrap && !full_q && !sample_valid;

        if (wrap) begin
            if (full_q) begin
                sh_l_d = hd_l_q;
                sh_r_d = hd_r_q;
            end else if (sample_valid) begin
                sh_l_d = sample_l;
                sh_r_d = sample_r;
            end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                sh_l_d = sh_l_q;
                sh_r_d = sh_r_q;
`else
                sh_l_d = '0;
                sh_r_d = '0;
`endif
            end
        end

        // Serial data and ws follow the position reached at this sck fall.
        lr   = (pos_nx >= PW'(BITS));
        rel  = lr ? pos_nx - PW'(BITS) : pos_nx;
        bidx = BW'(BITS - 1) - rel[BW-1:0];
        word = lr ? sh_r_d : sh_l_d;
        if (fall) begin
            sd_d = word[bidx];
            ws_d = lr ? (rel <= PW'(BITS - 2)) : (rel == PW'(BITS - 1));
        end

        if (!en) begin
            cnt_d  = '0;
            sck_d  = 1'b0;
            pos_d  = POS_LAST;
            ws_d   = 1'b0;
            sd_d   = 1'b0;
            sh_l_d = '0;
            sh_r_d = '0;
        end

        // Ready lags the holding register by one cycle after a frame pickup.
        hd_l_d = hd_l_q;
        hd_r_d = hd_r_q;
        full_d = full_q;
        rdy_d  = !full_q;
        if (wrap && full_q) begin
            full_d = 1'b0;
        end else if (xfer && !bypass) begin
            full_d = 1'b1;
            rdy_d  = 1'b0;
            hd_l_d = sample_l;
            hd_r_d = sample_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pos_q  <= POS_LAST;
            sck_q  <= 1'b0;
            ws_q   <= 1'b0;
            sd_q   <= 1'b0;
            fs_q   <= 1'b0;
            un_q   <= 1'b0;
            sh_l_q <= '0;
            sh_r_q <= '0;
            hd_l_q <= '0;
            hd_r_q <= '0;
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            sck_q  <= sck_d;
            ws_q   <= ws_d;
            sd_q   <= sd_d;
            fs_q   <= fs_d;
            un_q   <= un_d;
            sh_l_q <= sh_l_d;
            sh_r_q <= sh_r_d;
            hd_l_q <= hd_l_d;
            hd_r_q <= hd_r_d;
            full_q <= full_d;
            rdy_q  <= rdy_d;
        end
    end

    assign sample_ready = rdy_q;
    assign i2so_sck     = sck_q;
    assign i2so_ws      = ws_q;
    assign i2so_sd      = sd_q;
    assign frame_start  = fs_q;
    assign underrun     = un_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Bench for i2s_tx_scheduler: frame-level model (FIFO of accepted pairs, one per frame).
// Honors I2S_TX_REPEAT_ON_UNDERRUN_EN when defined for the build.
module tb_i2s_tx_scheduler;
    localparam int HALF  = 33;
    localparam int BITS  = 16;
    localparam int FRAME = 2 * BITS * 2 * HALF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [BITS-1:0] sample_l;
    logic [BITS-1:0] sample_r;
    logic            sample_valid;
    logic            sample_ready;
    logic            i2so_sck;
    logic            i2so_ws;
    logic            i2so_sd;
    logic            frame_start;
    logic            underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int man_cnt = 0;
    int man_done = 0;
    bit auto_src = 0;
    logic [BITS-1:0] man_l, man_r;
    logic [2*BITS-1:0] acc_q[$];
    logic [2*BITS-1:0] last_tx;

    always #5 clk = ~clk;

    i2s_tx_scheduler #(
        .CYC_PER_HALF_SCK(HALF),
        .BITS(BITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sample_l(sample_l),
        .sample_r(sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .i2so_sck(i2so_sck),
        .i2so_ws(i2so_ws),
        .i2so_sd(i2so_sd),
        .frame_start(frame_start),
        .underrun(underrun)
    );

    // Source: offers pairs, records every accepted pair in order.
    initial begin
        sample_valid = 1'b0;
        sample_l = '0;
        sample_r = '0;
        forever begin
            @(negedge clk);
            if (!sample_valid) begin
                if (man_done != man_cnt) begin
                    sample_l = man_l;
                    sample_r = man_r;
                    sample_valid = 1'b1;
                    man_done++;
                end else if (auto_src) begin
                    sample_l = BITS'($urandom);
                    sample_r = BITS'($urandom);
                    sample_valid = 1'b1;
                end
            end
            if (sample_valid && sample_ready && rst_n) begin
                @(posedge clk);
                #1;
                acc_q.push_back({sample_l, sample_r});
                n_acc++;
                sample_valid = 1'b0;
            end
        end
    end

    task automatic model_next(output logic [2*BITS-1:0] exp,
                              output logic exp_un);
        if (acc_q.size() > 0) begin
            exp = acc_q.pop_front();
            exp_un = 1'b0;
        end else begin
            exp_un = 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            exp = last_tx;
`else
            exp = '0;
`endif
        end
        last_tx = exp;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        forever begin
            @(posedge clk);
            #3;
            n++;
            if (frame_start) break;
            if (n > 2 * FRAME) begin
                n = -1;
                break;
            end
        end
    endtask

    // Called right after frame_start is sampled; captures sd/ws on sck rising.
    task automatic check_frame(input string tag, output logic r0,
                               output logic r1, output logic got_un);
        logic [2*BITS-1:0] exp, got_sd, got_ws, exp_ws;
        logic exp_un, prev, rise;
        int w;
        bit tmo;
        model_next(exp, exp_un);
        got_un = underrun;
        n_tests++;
        if (underrun !== exp_un) begin
            n_fail++;
            $display("FAIL %s underrun: got %b want %b", tag, underrun, exp_un);
        end
        r0 = sample_ready;
        @(posedge clk);
        #3;
        r1 = sample_ready;
        n_tests++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fs_width: got %b want 0", tag, frame_start);
        end
        got_sd = '0;
        got_ws = '0;
        tmo = 0;
        prev = i2so_sck;
        for (int p = 0; p < 2 * BITS; p++) begin
            exp_ws[2*BITS-1-p] = (p >= BITS - 1) && (p <= 2 * BITS - 2);
            w = 0;
            rise = 1'b0;
            while (!rise && w < 200) begin
                @(posedge clk);
                #3;
                w++;
                rise = i2so_sck && !prev;
                prev = i2so_sck;
            end
            if (!rise) tmo = 1;
            got_sd[2*BITS-1-p] = i2so_sd;
            got_ws[2*BITS-1-p] = i2so_ws;
        end
        n_tests++;
        if (tmo) begin
            n_fail++;
            $display("FAIL %s sck_timeout: got no edge want edge", tag);
        end
        n_tests++;
        if (got_sd !== exp) begin
            n_fail++;
            $display("FAIL %s sd: got %h want %h", tag, got_sd, exp);
        end
        n_tests++;
        if (got_ws !== exp_ws) begin
            n_fail++;
            $display("FAIL %s ws: got %h want %h", tag, got_ws, exp_ws);
        end
    endtask

    task automatic test_reset();
        bit bad;
        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if ({i2so_sck, i2so_ws, i2so_sd, frame_start, underrun,
             sample_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 000001",
                     {i2so_sck, i2so_ws, i2so_sd, frame_start, underrun,
                      sample_ready});
        end
        en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #3;
            if ({i2so_sck, i2so_ws, i2so_sd, frame_start, underrun,
                 sample_ready} !== 6'b000001) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle_after_reset: got activity want idle");
        end
    endtask

    task automatic test_first_frame();
        int n, w, a0;
        logic r0, r1, un;
        man_l = 16'hA5A5;
        man_r = 16'h3C3C;
        a0 = n_acc;
        man_cnt++;
        w = 0;
        while (n_acc == a0 && w < 20) begin
            @(posedge clk);
            #3;
            w++;
        end
        n_tests++;
        if (sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_load ready: got %b want 0", sample_ready);
        end
        @(posedge clk);
        #2;
        en = 1'b1;
        wait_fs(n);
        n_tests++;
        if (n !== 2 * HALF) begin
            n_fail++;
            $display("FAIL en_latency: got %0d want %0d", n, 2 * HALF);
        end
        check_frame("first", r0, r1, un);
        n_tests++;
        if (r0 !== 1'b0 || r1 !== 1'b1) begin
            n_fail++;
            $display("FAIL first ready_rise: got %b%b want 01", r0, r1);
        end
    endtask

    task automatic test_back_to_back();
        int n, a0;
        logic r0, r1, un;
        auto_src = 1;
        a0 = n_acc;
        for (int k = 0; k < 10; k++) begin
            wait_fs(n);
            n_tests++;
            if (n !== 33) begin
                n_fail++;
                $display("FAIL b2b period: got %0d want 33", n);
            end
            if (k > 0) begin
                n_tests++;
                if (n_acc - a0 !== 1) begin
                    n_fail++;
                    $display("FAIL b2b xfers: got %0d want 1", n_acc - a0);
                end
            end
            a0 = n_acc;
            check_frame("b2b", r0, r1, un);
            n_tests++;
            if (un !== 1'b0 || r0 !== 1'b0 || r1 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b flags: got un=%b rdy=%b%b want 0 01",
                         un, r0, r1);
            end
        end
    endtask

    task automatic test_underrun();
        int n;
        logic r0, r1, un;
        bit seen;
        auto_src = 0;
        seen = 0;
        for (int k = 0; k < 4 && !seen; k++) begin
            wait_fs(n);
            n_tests++;
            if (n !== 33) begin
                n_fail++;
                $display("FAIL underrun period: got %0d want 33", n);
            end
            check_frame("underrun", r0, r1, un);
            if (un === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL underrun seen: got 0 want 1");
        end
    endtask

    task automatic test_bypass();
        int n;
        logic r0, r1, un, exp_un;
        logic [2*BITS-1:0] exp;
        wait_fs(n);
        model_next(exp, exp_un);
        n_tests++;
        if (n !== 33 || underrun !== exp_un) begin
            n_fail++;
            $display("FAIL pre_bypass: got n=%0d un=%b want 33 %b",
                     n, underrun, exp_un);
        end
        repeat (FRAME - 1) @(posedge clk);
        #2;
        man_l = BITS'($urandom);
        man_r = BITS'($urandom);
        man_cnt++;
        wait_fs(n);
        n_tests++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL bypass timing: got %0d want 1", n);
        end
        check_frame("bypass", r0, r1, un);
        n_tests++;
        if (un !== 1'b0 || r0 !== 1'b1 || r1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass flags: got un=%b rdy=%b%b want 0 11",
                     un, r0, r1);
        end
    endtask

    task automatic test_en_drop();
        int n, f, w;
        logic r0, r1, un, exp_un, prev;
        logic [2*BITS-1:0] exp;
        auto_src = 1;
        wait_fs(n);
        model_next(exp, exp_un);
        n_tests++;
        if (n !== 33 || underrun !== exp_un) begin
            n_fail++;
            $display("FAIL pre_drop: got n=%0d un=%b want 33 %b",
                     n, underrun, exp_un);
        end
        prev = i2so_sck;
        f = 0;
        w = 0;
        while (f < 9 && w < 2000) begin
            @(posedge clk);
            #3;
            w++;
            if (!i2so_sck && prev) f++;
            prev = i2so_sck;
        end
        n_tests++;
        if (i2so_sd !== exp[2*BITS-1-9] || i2so_ws !== 1'b0) begin
            n_fail++;
            $display("FAIL pos9: got sd=%b ws=%b want %b 0",
                     i2so_sd, i2so_ws, exp[2*BITS-1-9]);
        end
        @(posedge clk);
        #2;
        en = 1'b0;
        @(posedge clk);
        #3;
        n_tests++;
        if ({i2so_sck, i2so_ws, i2so_sd, frame_start, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL en_low: got %b want 00000",
                     {i2so_sck, i2so_ws, i2so_sd, frame_start, underrun});
        end
        last_tx = '0;
        repeat (20) @(posedge clk);
        #3;
        n_tests++;
        if (sample_ready !== 1'b0 || {i2so_sck, i2so_ws, i2so_sd} !== 3'b0) begin
            n_fail++;
            $display("FAIL en_low hold: got rdy=%b out=%b want 0 000",
                     sample_ready, {i2so_sck, i2so_ws, i2so_sd});
        end
        @(posedge clk);
        #2;
        en = 1'b1;
        wait_fs(n);
        n_tests++;
        if (n !== 2 * HALF) begin
            n_fail++;
            $display("FAIL resume latency: got %0d want %0d", n, 2 * HALF);
        end
        check_frame("resume", r0, r1, un);
    endtask

    task automatic test_async_reset();
        int n, w;
        logic r0, r1, un;
        auto_src = 0;
        w = 0;
        while (sample_valid && w < 3000) begin
            @(posedge clk);
            #3;
            w++;
        end
        repeat (5) @(posedge clk);
        #3;
        n_tests++;
        if (sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset hold: got rdy=%b want 0", sample_ready);
        end
        @(posedge clk);
        #7;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({i2so_sck, i2so_ws, i2so_sd, frame_start, underrun,
             sample_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 000001",
                     {i2so_sck, i2so_ws, i2so_sd, frame_start, underrun,
                      sample_ready});
        end
        acc_q.delete();
        last_tx = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_fs(n);
        n_tests++;
        if (n !== 2 * HALF) begin
            n_fail++;
            $display("FAIL post_reset latency: got %0d want %0d", n, 2 * HALF);
        end
        check_frame("post_reset", r0, r1, un);
        n_tests++;
        if (un !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset empty: got un=%b want 1", un);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        man_l = '0;
        man_r = '0;
        last_tx = '0;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_underrun();
        test_bypass();
        test_en_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_scheduler.md
Name: i2s_tx_scheduler

Overview:
Output-side I2S master controller for the chip's audio path. It generates the serial clock and word select for the 100 MHz system clock domain. It accepts processed stereo samples from the datapath through a valid/ready handshake into a one-frame holding register. It then serializes each frame MSB-first on the I2S output pins and flags underruns.

Parameters:
CYC_PER_HALF_SCK, 33, clk cycles per sck half-period (100 MHz / 1.5 MHz / 2)
BITS, 16, bits per channel word

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; low = stopped, outputs idle
sample_l  input  BITS  left-channel sample
sample_r  input  BITS  right-channel sample
sample_valid  input  1  sample pair offered
sample_ready  output  1  holding register empty; transfer occurs when valid & ready
i2so_sck  output  1  I2S serial clock
i2so_ws  output  1  I2S word select
i2so_sd  output  1  I2S serial data
frame_start  output  1  one-cycle pulse when a new frame begins (left MSB driven)
underrun  output  1  one-cycle pulse when a frame begins with no data held

Behaviour:
- Reset (async, rst_n low): sck=0, ws=0, sd=0, frame_start=0, underrun=0. sample_ready=1. Holding register and shift register are cleared. Half-period counter=0 and frame position=2*BITS-1.
- All outputs are registered. Only clk is used; there are no derived clock domains.
- Half-period counter: while en=1, it counts 0..CYC_PER_HALF_SCK-1. On terminal count it wraps to 0 and toggles sck. Resulting sck period = 2*CYC_PER_HALF_SCK clk cycles (66).
- Frame position pos, range 0..2*BITS-1: lr=pos/BITS (0 = left), bit=pos%BITS.
- pos advances (wrapping 2*BITS-1 -> 0) only in the clk cycle where sck toggles 1->0. ws and sd update in that same cycle, so they change coincident with sck falling.
- sd = shift word[lr] bit (BITS-1-bit), MSB first.
- ws = 1 when (lr=1 and bit<=BITS-2) or (lr=0 and bit=BITS-1); otherwise 0. This gives the standard one-bit lead ahead of the channel MSB.
- Frame boundary (pos wraps to 0):
  - Holding register full: move its contents into the shift register, then set ready=1 on the next cycle.
  - Holding register empty but valid=1 in the same cycle: bypass the input directly into the shift register. No underrun, ready stays 1.
  - Holding register empty and valid=0: load zeros into the shift register and pulse underrun.
  - frame_start pulses in every boundary cycle.
- Handshake: the holding register loads on valid & ready, and ready drops the next cycle. At most one transfer per frame. Inputs must hold while valid=1 and ready=0.
- en low, sampled at any clk: next cycle sck=0, ws=0, sd=0, half-period counter=0, pos=2*BITS-1, shift register cleared, no pulses.
  - The holding register and the handshake keep operating while en is low.
- en rising: the first sck falling edge (and first frame_start) arrives exactly 2*CYC_PER_HALF_SCK (66) cycles after the first cycle en is sampled high.
- Frame length = 2*BITS*2*CYC_PER_HALF_SCK = 2112 clk cycles.

Optional Feature:
I2S_TX_REPEAT_ON_UNDERRUN_EN:
- Defined: on an underrun boundary the shift register keeps its previous frame, so the last sample pair is retransmitted. The underrun pulse is still asserted.
- Undefined: zeros are transmitted on underrun.
- Reset and en-low always clear the shift register to zero in both builds.

Test Plan:
1. Reset: hold rst_n low with en=1 -> sck/ws/sd/frame_start/underrun=0 and sample_ready=1. Deassert rst_n with en=0 -> outputs stay 0.
2. Load L=16'hA5A5, R=16'h3C3C, then raise en -> frame_start at cycle 66. Captured on sck rising, sd reads 1010010110100101 then 0011110000111100. ws=1 for pos 15..30, 0 otherwise.
3. Back-to-back frames: source re-offers a new pair as soon as ready rises -> exactly one transfer per frame, ready rises 1 cycle after each frame_start, underrun never pulses over 10 frames.
4. Underrun: no sample offered for one frame -> underrun pulses with frame_start. sd=0 for all 32 bits without the macro; with I2S_TX_REPEAT_ON_UNDERRUN_EN, the previous pair repeats bit-exact.
5. Bypass: valid rises in the exact boundary cycle with the holding register empty -> that pair is transmitted in the current frame, no underrun.
6. Mid-frame disruptions:
   - Drop en at pos 9 -> next cycle sck=ws=sd=0. Re-enable -> frame_start after 66 cycles with the held sample.
   - Repeat with an async rst_n pulse mid-cycle -> immediate clear; holding register empty, ready=1.
